// File: rtl/cpu_pipe_ctrl_pkg.sv
// rtl/cpu_pipe_ctrl_pkg.sv - shared FSM states and forwarding-select encodings
package cpu_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/cpu_fwd_unit.sv
// rtl/cpu_fwd_unit.sv - operand forwarding select for one source register
module cpu_fwd_unit
  import cpu_pipe_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       src_used_i,
  input  logic       ex_wen_i,
  input  logic [4:0] ex_num_i,
  input  logic       ex_load_i,
  input  logic       mem_wen_i,
  input  logic [4:0] mem_num_i,
  output logic [1:0] sel_o
);

  // EX wins over MEM (younger value); a load in EX has no result yet, so fall through to MEM
  always_comb begin
    sel_o = FWD_RF;
    if (!src_used_i) begin
      sel_o = FWD_RF;
    end else if (ex_wen_i && (ex_num_i != 5'd0) && (ex_num_i == src_i) && !ex_load_i) begin
      sel_o = FWD_EX;
    end else if (mem_wen_i && (mem_num_i != 5'd0) && (mem_num_i == src_i)) begin
      sel_o = FWD_MEM;
    end
  end

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// rtl/cpu_pipe_ctrl.sv - pipeline hazard, forwarding and halt controller
module cpu_pipe_ctrl
  import cpu_pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             reg_write_en_ex,
  input  logic [4:0]       reg_write_num_ex,
  input  logic             mem_read_ex,
  input  logic             reg_write_en_mem,
  input  logic [4:0]       reg_write_num_mem,
  input  logic             branch_taken_ex,
  input  logic             halt_req_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halt,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_count_q, flush_count_q;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             load_use;
  logic             load_use_stall;
  logic             branch_flush;

  cpu_fwd_unit u_fwd_rs (
    .src_i      (rs_id),
    .src_used_i (1'b1),
    .ex_wen_i   (reg_write_en_ex),
    .ex_num_i   (reg_write_num_ex),
    .ex_load_i  (mem_read_ex),
    .mem_wen_i  (reg_write_en_mem),
    .mem_num_i  (reg_write_num_mem),
    .sel_o      (fwd_a_raw)
  );

  cpu_fwd_unit u_fwd_rt (
    .src_i      (rt_id),
    .src_used_i (uses_rt_id),
    .ex_wen_i   (reg_write_en_ex),
    .ex_num_i   (reg_write_num_ex),
    .ex_load_i  (mem_read_ex),
    .mem_wen_i  (reg_write_en_mem),
    .mem_num_i  (reg_write_num_mem),
    .sel_o      (fwd_b_raw)
  );

  assign load_use = mem_read_ex && reg_write_en_ex && (reg_write_num_ex != 5'd0) &&
                    ((reg_write_num_ex == rs_id) || (uses_rt_id && (reg_write_num_ex == rt_id)));

  assign fwd_a_sel   = clr ? fwd_a_raw : FWD_RF;
  assign fwd_b_sel   = clr ? fwd_b_raw : FWD_RF;
  assign halt        = (state_q == HALTED);
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

  // State and drain counter register
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next state: halt request starts the drain, drain expiry stops the pipe for good
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: begin
        if (halt_req_ex) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = HALTED;
          end else begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        if (drain_q <= DW'(1)) begin
          drain_d = '0;
          state_d = HALTED;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Stall/flush outputs; priority in RUN is halt, then branch, then load-use
  always_comb begin
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    load_use_stall = 1'b0;
    branch_flush   = 1'b0;
    if (clr) begin
      unique case (state_q)
        RUN: begin
          if (halt_req_ex) begin
            stall_if = 1'b1;
            flush_id = 1'b1;
          end else if (branch_taken_ex) begin
            flush_id     = 1'b1;
            flush_ex     = 1'b1;
            branch_flush = 1'b1;
          end else if (load_use) begin
            stall_if       = 1'b1;
            stall_id       = 1'b1;
            flush_ex       = 1'b1;
            load_use_stall = 1'b1;
          end
        end
        DRAIN: begin
          stall_if = 1'b1;
          flush_id = 1'b1;
        end
        HALTED: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_id = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!clr) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (load_use_stall && (stall_count_q != '1)) stall_count_q <= stall_count_q + CNT_W'(1);
      if (branch_flush && (flush_count_q != '1)) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// tb/tb_cpu_pipe_ctrl.sv - scoreboard bench for cpu_pipe_ctrl
module tb_cpu_pipe_ctrl;

  localparam int DRAIN = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr;
  logic [4:0]    rs_id, rt_id, reg_write_num_ex, reg_write_num_mem;
  logic          uses_rt_id, reg_write_en_ex, mem_read_ex, reg_write_en_mem;
  logic          branch_taken_ex, halt_req_ex;
  logic          stall_if, stall_id, flush_id, flush_ex, halt;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  cpu_pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk               (clk),
    .clr               (clr),
    .rs_id             (rs_id),
    .rt_id             (rt_id),
    .uses_rt_id        (uses_rt_id),
    .reg_write_en_ex   (reg_write_en_ex),
    .reg_write_num_ex  (reg_write_num_ex),
    .mem_read_ex       (mem_read_ex),
    .reg_write_en_mem  (reg_write_en_mem),
    .reg_write_num_mem (reg_write_num_mem),
    .branch_taken_ex   (branch_taken_ex),
    .halt_req_ex       (halt_req_ex),
    .stall_if          (stall_if),
    .stall_id          (stall_id),
    .flush_id          (flush_id),
    .flush_ex          (flush_ex),
    .fwd_a_sel         (fwd_a_sel),
    .fwd_b_sel         (fwd_b_sel),
    .halt              (halt),
    .stall_count       (stall_count),
    .flush_count       (flush_count)
  );

  typedef struct {
    int sif, sid, fid, fex, hlt, fa, fb, sc, fc;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   n_chk = 0, n_err = 0, n_push = 0, n_pop = 0, cyc = 0;

  // Reference state: halted flag, remaining drain cycles, event counts
  bit m_halted = 0;
  int m_drain = 0, m_sc = 0, m_fc = 0;

  function automatic int fwd_ref(input int src, input bit ewen, input int enum_, input bit eld,
                                 input bit mwen, input int mnum);
    if (ewen && enum_ != 0 && enum_ == src && !eld) return 1;
    if (mwen && mnum != 0 && mnum == src) return 2;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic step(input bit c, input int rs, input int rt, input bit u, input bit ewen,
                      input int enum_, input bit eld, input bit mwen, input int mnum,
                      input bit br, input bit hr);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    clr = c; rs_id = 5'(rs); rt_id = 5'(rt); uses_rt_id = u;
    reg_write_en_ex = ewen; reg_write_num_ex = 5'(enum_); mem_read_ex = eld;
    reg_write_en_mem = mwen; reg_write_num_mem = 5'(mnum);
    branch_taken_ex = br; halt_req_ex = hr;
    e = '{default: 0};
    e.sc  = m_sc;
    e.fc  = m_fc;
    e.hlt = int'(m_halted);
    if (!c) begin
      m_halted = 0; m_drain = 0; m_sc = 0; m_fc = 0;
    end else begin
      e.fa = fwd_ref(rs, ewen, enum_, eld, mwen, mnum);
      e.fb = u ? fwd_ref(rt, ewen, enum_, eld, mwen, mnum) : 0;
      lu = eld && ewen && enum_ != 0 && (enum_ == rs || (u && enum_ == rt));
      if (m_halted) begin
        e.sif = 1; e.sid = 1; e.fid = 1;
      end else if (m_drain > 0) begin
        e.sif = 1; e.fid = 1;
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end else if (hr) begin
        e.sif = 1; e.fid = 1;
        if (DRAIN == 0) m_halted = 1;
        else m_drain = DRAIN;
      end else if (br) begin
        e.fid = 1; e.fex = 1;
        if (m_fc < CMAX) m_fc++;
      end else if (lu) begin
        e.sif = 1; e.sid = 1; e.fex = 1;
        if (m_sc < CMAX) m_sc++;
      end
    end
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pop one expectation per cycle and compare away from the clock edge
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      n_pop++;
      chk("outputs_known", int'($isunknown({stall_if, stall_id, flush_id, flush_ex, halt,
                                             fwd_a_sel, fwd_b_sel, stall_count, flush_count})), 0);
      chk("stall_if", int'(stall_if), me.sif);
      chk("stall_id", int'(stall_id), me.sid);
      chk("flush_id", int'(flush_id), me.fid);
      chk("flush_ex", int'(flush_ex), me.fex);
      chk("halt", int'(halt), me.hlt);
      chk("fwd_a_sel", int'(fwd_a_sel), me.fa);
      chk("fwd_b_sel", int'(fwd_b_sel), me.fb);
      chk("stall_count", int'(stall_count), me.sc);
      chk("flush_count", int'(flush_count), me.fc);
    end
  end

  initial begin
    clr = 1'b0; rs_id = '0; rt_id = '0; uses_rt_id = 1'b0;
    reg_write_en_ex = 1'b0; reg_write_num_ex = '0; mem_read_ex = 1'b0;
    reg_write_en_mem = 1'b0; reg_write_num_mem = '0;
    branch_taken_ex = 1'b0; halt_req_ex = 1'b0;
    @(posedge clk);
    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 3, 3, 1, 1, 3, 1, 1, 3, 1, 0);
    idle();
    // load-use on rs, then forward from MEM
    step(1, 8, 0, 0, 1, 8, 1, 0, 0, 0, 0);
    step(1, 8, 0, 0, 0, 0, 0, 1, 8, 0, 0);
    // EX beats MEM for same register
    step(1, 9, 0, 0, 1, 9, 0, 1, 9, 0, 0);
    // $0 never forwards
    step(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    // rt hazard only when rt is used
    step(1, 1, 5, 1, 1, 5, 1, 0, 0, 0, 0);
    step(1, 1, 5, 0, 1, 5, 1, 0, 0, 0, 0);
    step(1, 7, 6, 1, 1, 6, 0, 1, 7, 0, 0);
    // branch overrides load-use
    step(1, 8, 0, 0, 1, 8, 1, 0, 0, 1, 0);
    // halt overrides branch, branches ignored while draining
    step(1, 8, 0, 0, 1, 8, 1, 0, 0, 1, 1);
    step(1, 8, 0, 0, 1, 8, 1, 0, 0, 1, 0);
    step(1, 8, 0, 0, 1, 8, 1, 0, 0, 1, 0);
    step(1, 8, 0, 0, 1, 8, 1, 0, 0, 1, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // reset while halted
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // randomized traffic on a small register set for dense hazards and counter saturation
    for (int i = 0; i < 1200; i++) begin
      bit c, u, ew, ld, mw, br, hr;
      int rs, rt, ne, nm;
      c  = ($urandom_range(0, 79) != 0);
      rs = int'($urandom_range(0, 3));
      rt = int'($urandom_range(0, 3));
      ne = int'($urandom_range(0, 3));
      nm = int'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      ew = ($urandom_range(0, 3) != 0);
      ld = 1'($urandom_range(0, 1));
      mw = 1'($urandom_range(0, 1));
      br = ($urandom_range(0, 5) == 0);
      hr = ($urandom_range(0, 59) == 0);
      step(c, rs, rt, u, ew, ne, ld, mw, nm, br, hr);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", n_pop, n_push);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
